// File: rtl/spmv_kernel_dispatcher.sv
// spmv_kernel_dispatcher: per-kernel SpMV job sequencing with round-robin launch arbitration
module spmv_kernel_dispatcher #(
    parameter int          CONF_NUM_KERNEL = 4,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'h00FF_FFFF,
    parameter int          CNT_W           = 24
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [96*CONF_NUM_KERNEL-1:0]        config_wire,
    output logic                                 job_valid,
    input  logic                                 job_ready,
    output logic [$clog2(CONF_NUM_KERNEL)-1:0]   job_kernel,
    output logic [31:0]                          job_row_num,
    output logic [31:0]                          job_nnz_num,
    input  logic [CONF_NUM_KERNEL-1:0]           kernel_done,
    output logic [32*CONF_NUM_KERNEL-1:0]        status,
    output logic                                 irq
);
    localparam int N  = CONF_NUM_KERNEL;
    localparam int KW = $clog2(CONF_NUM_KERNEL);

    typedef enum logic [2:0] {IDLE, PENDING, RUNNING, DONE, ERROR} state_t;

    state_t           st       [N];
    state_t           st_nxt   [N];
    logic [31:0]      cfg_row  [N];
    logic [31:0]      cfg_nnz  [N];
    logic [31:0]      snap_row [N];
    logic [31:0]      snap_nnz [N];
    logic [CNT_W-1:0] cnt      [N];
    logic [CNT_W-1:0] cnt_inc  [N];
    logic [N-1:0]     start_q, start_edge, clear, timeout, enter_end;
    logic [N-1:0]     err_cfg, err_to, spurious;
    logic [30*N-1:0]  unused_ctrl;
    logic [KW-1:0]    ptr, sel, idx;
    logic             found, handshake;

    assign handshake = job_valid & job_ready;

    // Decode the config bus into per-kernel fields and derive per-cycle events
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cfg_row[i]               = config_wire[96*i+32 +: 32];
            cfg_nnz[i]               = config_wire[96*i+64 +: 32];
            start_edge[i]            = config_wire[96*i] & ~start_q[i];
            clear[i]                 = config_wire[96*i+1];
            unused_ctrl[30*i +: 30]  = config_wire[96*i+2 +: 30];
            cnt_inc[i]               = (&cnt[i]) ? cnt[i] : cnt[i] + 1'b1;
            timeout[i]               = 32'(cnt_inc[i]) >= TIMEOUT_CYCLES;
        end
    end

    // Per-kernel next state; the launch handshake is the only way into RUNNING
    always_comb begin
        for (int i = 0; i < N; i++) begin
            st_nxt[i] = st[i];
            case (st[i])
                IDLE:    if (start_edge[i]) st_nxt[i] = (cfg_row[i] == '0 || cfg_nnz[i] == '0) ? ERROR : PENDING;
                PENDING: if (handshake && job_kernel == KW'(i)) st_nxt[i] = RUNNING;
                RUNNING: st_nxt[i] = kernel_done[i] ? DONE : timeout[i] ? ERROR : RUNNING;
                default: if (clear[i]) st_nxt[i] = IDLE;
            endcase
            enter_end[i] = (st_nxt[i] != st[i]) && (st_nxt[i] == DONE || st_nxt[i] == ERROR);
        end
    end

    // Pick the first PENDING kernel at or after the round-robin pointer
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = ptr;
        for (int k = 0; k < N; k++) begin
            idx = KW'((32'(ptr) + 32'(k)) % N);
            if (!found && st[idx] == PENDING) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Kernel state, job snapshots, run counters and sticky flags; clear wipes the sticky set
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N; i++) begin
                st[i]       <= IDLE;
                snap_row[i] <= '0;
                snap_nnz[i] <= '0;
                cnt[i]      <= '0;
            end
            start_q  <= '0;
            err_cfg  <= '0;
            err_to   <= '0;
            spurious <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                st[i]      <= st_nxt[i];
                start_q[i] <= config_wire[96*i];
                if (st[i] == IDLE && st_nxt[i] == PENDING) begin
                    snap_row[i] <= cfg_row[i];
                    snap_nnz[i] <= cfg_nnz[i];
                end
                if (st[i] == RUNNING) cnt[i] <= cnt_inc[i];
                if (st[i] == IDLE && st_nxt[i] == ERROR) err_cfg[i] <= 1'b1;
                if (st[i] == RUNNING && st_nxt[i] == ERROR) err_to[i] <= 1'b1;
                if (kernel_done[i] && st[i] != RUNNING) spurious[i] <= 1'b1;
                if (st[i] != IDLE && st_nxt[i] == IDLE) begin
                    cnt[i]      <= '0;
                    err_cfg[i]  <= 1'b0;
                    err_to[i]   <= 1'b0;
                    spurious[i] <= 1'b0;
                end
            end
        end
    end

    // Launch port holds one job until accepted; irq flags any DONE/ERROR entry
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            job_valid   <= 1'b0;
            job_kernel  <= '0;
            job_row_num <= '0;
            job_nnz_num <= '0;
            ptr         <= '0;
            irq         <= 1'b0;
        end else begin
            irq <= |enter_end;
            if (handshake) begin
                job_valid <= 1'b0;
                ptr       <= (job_kernel == KW'(N - 1)) ? '0 : job_kernel + 1'b1;
            end else if (!job_valid && found) begin
                job_valid   <= 1'b1;
                job_kernel  <= sel;
                job_row_num <= snap_row[sel];
                job_nnz_num <= snap_nnz[sel];
            end
        end
    end

    // Pack status words: state one-hot, sticky flags, then the run counter
    always_comb begin
        status = '0;
        for (int i = 0; i < N; i++) begin
            status[32*i +: 32] = {24'(cnt[i]), 1'b0, spurious[i], err_to[i], err_cfg[i],
                                  st[i] == ERROR, st[i] == DONE, st[i] == RUNNING, st[i] == PENDING};
        end
    end
endmodule
